// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester ram arbiter: FSM encoding and
// default ram geometry.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 64;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that did
// not own the ram last time wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = (req == 2'b11) ? ~last_owner : req[1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer for a single-port ram shared by
// two client engines. All ram-facing outputs are registered.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_din,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_din,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_dout,
    output logic              cen,
    output logic              wen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_din,
    input  logic [DATA_W-1:0] s_dout
);

    state_t              state_reg, state_next;
    logic                cen_reg, cen_next;
    logic                wen_reg, wen_next;
    logic [ADDR_W-1:0]   s_addr_reg, s_addr_next;
    logic [DATA_W-1:0]   s_din_reg, s_din_next;
    logic                owner_reg, owner_next;
    logic                last_owner_reg, last_owner_next;

    logic                pick_valid;
    logic                pick_winner;

    rr_pick2 u_pick (
        .req        ({m1_req, m0_req}),
        .last_owner (last_owner_reg),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            cen_reg        <= 1'b0;
            wen_reg        <= 1'b0;
            s_addr_reg     <= '0;
            s_din_reg      <= '0;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cen_reg        <= cen_next;
            wen_reg        <= wen_next;
            s_addr_reg     <= s_addr_next;
            s_din_reg      <= s_din_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
        end
    end

    // cen/wen default low so every access is exactly one ram cycle; address
    // and data hold their last latched values between accesses.
    always_comb begin
        state_next      = state_reg;
        cen_next        = 1'b0;
        wen_next        = 1'b0;
        s_addr_next     = s_addr_reg;
        s_din_next      = s_din_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next      = ST_ISSUE;
                    cen_next        = 1'b1;
                    wen_next        = pick_winner ? m1_wen  : m0_wen;
                    s_addr_next     = pick_winner ? m1_addr : m0_addr;
                    s_din_next      = pick_winner ? m1_din  : m0_din;
                    owner_next      = pick_winner;
                    last_owner_next = pick_winner;
                end
            end
            ST_ISSUE: state_next = wen_reg ? ST_IDLE : ST_RDATA;
            ST_RDATA: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    logic [1:0]        gnt_vec;
    logic [1:0]        rvalid_vec;
    logic [DATA_W-1:0] dout_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign gnt_vec[gi]    = (state_reg == ST_ISSUE) && (owner_reg == 1'(gi));
        assign rvalid_vec[gi] = (state_reg == ST_RDATA) && (owner_reg == 1'(gi));
        assign dout_arr[gi]   = rvalid_vec[gi] ? s_dout : '0;
    end

    assign m0_gnt    = gnt_vec[0];
    assign m1_gnt    = gnt_vec[1];
    assign m0_rvalid = rvalid_vec[0];
    assign m1_rvalid = rvalid_vec[1];
    assign m0_dout   = dout_arr[0];
    assign m1_dout   = dout_arr[1];

    assign cen    = cen_reg;
    assign wen    = wen_reg;
    assign s_addr = s_addr_reg;
    assign s_din  = s_din_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 256x64 single-port ram.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m0_wen = 1'b0;
    logic [7:0]  m0_addr = '0;
    logic [63:0] m0_din = '0;
    logic        m0_gnt, m0_rvalid;
    logic [63:0] m0_dout;
    logic        m1_req = 1'b0, m1_wen = 1'b0;
    logic [7:0]  m1_addr = '0;
    logic [63:0] m1_din = '0;
    logic        m1_gnt, m1_rvalid;
    logic [63:0] m1_dout;
    logic        cen, wen;
    logic [7:0]  s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout = '0;

    int n_assert = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(8), .DATA_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_dout(m1_dout),
        .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
    );

    // Behavioural single-port ram: read data appears the cycle after sampling.
    logic [63:0] mem [256];
    always @(posedge clk) begin
        if (cen) begin
            if (wen) mem[s_addr] <= s_din;
            else     s_dout <= mem[s_addr];
        end
    end

    typedef struct {
        bit          is_rd;
        bit          port;
        bit          w;
        logic [7:0]  addr;
        logic [63:0] data;
        int          gap;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input bit is_rd, input bit port, input bit w,
                        input logic [7:0] a, input logic [63:0] d, input int gap);
        exp_t e;
        e.is_rd = is_rd; e.port = port; e.w = w; e.addr = a; e.data = d; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per gnt/rvalid event, checks invariants every cycle.
    int cyc = 0;
    int last_gnt_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en) begin
            chk("two_gnt", {63'd0, m0_gnt & m1_gnt}, 64'd0);
            chk("gnt_and_rvalid", {63'd0, (m0_gnt | m1_gnt) & (m0_rvalid | m1_rvalid)}, 64'd0);
            chk("wen_without_cen", {63'd0, wen & ~cen}, 64'd0);
            if (!m0_rvalid) chk("m0_dout_idle", m0_dout, 64'd0);
            if (!m1_rvalid) chk("m1_dout_idle", m1_dout, 64'd0);
            if (m0_gnt || m1_gnt) begin
                if (exp_q.size() == 0 || exp_q[0].is_rd) begin
                    chk("unexpected_gnt", {63'd0, m1_gnt}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt_port", {63'd0, m1_gnt}, {63'd0, e.port});
                    chk("gnt_cen", {63'd0, cen}, 64'd1);
                    chk("gnt_wen", {63'd0, wen}, {63'd0, e.w});
                    chk("gnt_addr", {56'd0, s_addr}, {56'd0, e.addr});
                    if (e.w) chk("gnt_din", s_din, e.data);
                    if (e.gap != 0) chk("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'(e.gap));
                    last_gnt_cyc = cyc;
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                if (exp_q.size() == 0 || !exp_q[0].is_rd) begin
                    chk("unexpected_rvalid", {63'd0, m1_rvalid}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("rv_port", {63'd0, m1_rvalid}, {63'd0, e.port});
                    chk("rv_dout", e.port ? m1_dout : m0_dout, e.data);
                    chk("rv_other_dout", e.port ? m0_dout : m1_dout, 64'd0);
                    chk("rv_cen", {63'd0, cen}, 64'd0);
                    chk("rv_addr_hold", {56'd0, s_addr}, {56'd0, e.addr});
                end
            end
        end
    end

    // Requester driver: holds req until gnt, then keeps it for the next access or drops it.
    task automatic do_req(input bit port, input bit w, input logic [7:0] a,
                          input logic [63:0] d, input int n, input bit chg_addr);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            bit got = 1'b0;
            if (port) begin m1_req = 1'b1; m1_wen = w; m1_addr = a; m1_din = d; end
            else      begin m0_req = 1'b1; m0_wen = w; m0_addr = a; m0_din = d; end
            while (!got && t < 50) begin
                @(negedge clk);
                t++;
                got = port ? m1_gnt : m0_gnt;
            end
            if (!got) chk("gnt_timeout", {63'd0, got}, 64'd1);
            if (chg_addr) begin
                #1;
                if (port) m1_addr = 8'h10; else m0_addr = 8'h10;
            end
            @(posedge clk);
            #1;
        end
        if (port) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cen", {63'd0, cen}, 64'd0);
        chk("rst_wen", {63'd0, wen}, 64'd0);
        chk("rst_addr", {56'd0, s_addr}, 64'd0);
        chk("rst_din", s_din, 64'd0);
        chk("rst_gnt_rvalid", {60'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        // m0 write 00
        push(0, 0, 1, 8'h00, 64'h1111_2222_EEEE_FFFF, 0);
        do_req(0, 1, 8'h00, 64'h1111_2222_EEEE_FFFF, 1, 0);
        @(negedge clk);
        chk("write_cen_one_cycle", {63'd0, cen}, 64'd0);
        drain();

        // m1 read 00
        push(0, 1, 0, 8'h00, 64'd0, 0);
        push(1, 1, 0, 8'h00, 64'h1111_2222_EEEE_FFFF, 0);
        do_req(1, 0, 8'h00, 64'd0, 1, 0);
        drain();

        // Both request continuously: grants alternate m0,m1,m0,m1
        push(0, 0, 1, 8'h02, 64'h1234_2345_3456_4567, 0);
        push(0, 1, 1, 8'h05, 64'hAAAA_5555_0F0F_F0F0, 2);
        push(0, 0, 1, 8'h02, 64'h1234_2345_3456_4567, 2);
        push(0, 1, 1, 8'h05, 64'hAAAA_5555_0F0F_F0F0, 2);
        fork
            do_req(0, 1, 8'h02, 64'h1234_2345_3456_4567, 2, 0);
            do_req(1, 1, 8'h05, 64'hAAAA_5555_0F0F_F0F0, 2, 0);
        join
        drain();

        // m1 alone: three reads of 02 at 3-cycle spacing
        for (int k = 0; k < 3; k++) begin
            push(0, 1, 0, 8'h02, 64'd0, (k == 0) ? 0 : 3);
            push(1, 1, 0, 8'h02, 64'h1234_2345_3456_4567, 0);
        end
        do_req(1, 0, 8'h02, 64'd0, 3, 0);
        drain();

        // Reset during ISSUE of a read: access aborted, no rvalid
        begin
            int t = 0;
            push(0, 1, 0, 8'h02, 64'd0, 0);
            m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 8'h02;
            while (!m1_gnt && t < 50) begin @(negedge clk); t++; end
            chk("abort_gnt_seen", {63'd0, m1_gnt}, 64'd1);
            #1;
            reset_n = 1'b0;
            m1_req  = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            @(negedge clk);
            chk("abort_cen", {63'd0, cen}, 64'd0);
            chk("abort_addr", {56'd0, s_addr}, 64'd0);
            repeat (4) @(negedge clk);
            exp_q.delete();
        end

        // m0 read 05, address input changed during ISSUE must be ignored
        push(0, 0, 0, 8'h05, 64'd0, 0);
        push(1, 0, 0, 8'h05, 64'hAAAA_5555_0F0F_F0F0, 0);
        do_req(0, 0, 8'h05, 64'd0, 1, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
